// File: rtl/multimode_ff_bank_if.sv
// Bus bundle for multimode_ff_bank: control and data inputs, state and status outputs.
// The master drives the controls; the slave (the bank) drives the state.
interface multimode_ff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             err;
    logic [WIDTH-1:0] err_mask;
    logic [CNT_W-1:0] chg_cnt;

    modport master (
        output en, mode, a, b, load, load_val, clr_err,
        input  q, qn, err, err_mask, chg_cnt
    );

    modport slave (
        input  en, mode, a, b, load, load_val, clr_err,
        output q, qn, err, err_mask, chg_cnt
    );
endinterface

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH flip-flops behaving as D/T/JK/SR per the mode input, with parallel
// load, sticky illegal-SR record and a saturating count of state-changing edges.
module multimode_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                clk,
    input logic                rst_n,
    multimode_ff_bank_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] err_mask_r;
    logic [CNT_W-1:0] chg_cnt_r;

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] illegal;
    logic [WIDTH-1:0] err_mask_nxt;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    always_comb begin
        // NOTE: defaults first so every path assigns q_nxt/illegal and no latch is inferred.
        q_nxt   = q_r;
        illegal = '0;
        if (bus.load) begin
            q_nxt = bus.load_val;
        end else if (bus.en) begin
            unique case (mode)
                MODE_D:  q_nxt = bus.a;
                MODE_T:  q_nxt = q_r ^ bus.a;
                MODE_JK: q_nxt = (bus.a & ~q_r) | (~bus.b & q_r);
                MODE_SR: begin
                    // S=R=1 holds the bit; only the exclusive set/reset cases move it.
                    q_nxt   = (q_r | (bus.a & ~bus.b)) & ~(bus.b & ~bus.a);
                    illegal = bus.a & bus.b;
                end
                default: q_nxt = q_r;
            endcase
        end
    end

    // A fresh illegal bit on the clearing edge survives the clear.
    assign err_mask_nxt = bus.clr_err ? illegal : (err_mask_r | illegal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r        <= RESET_VAL;
            err_mask_r <= '0;
            chg_cnt_r  <= '0;
        end else begin
            // NOTE: non-blocking so all three registers update from the same pre-edge state.
            q_r        <= q_nxt;
            err_mask_r <= err_mask_nxt;
            if ((q_nxt != q_r) && (chg_cnt_r != CNT_MAX))
                chg_cnt_r <= chg_cnt_r + 1'b1;
        end
    end

    assign bus.q        = q_r;
    assign bus.qn       = ~q_r;
    assign bus.err_mask = err_mask_r;
    assign bus.err      = |err_mask_r;
    assign bus.chg_cnt  = chg_cnt_r;
endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed self-checking bench for multimode_ff_bank: reset, JK, SR errors, priority,
// counter saturation and a randomised D-mode run against a small reference model.
module tb_multimode_ff_bank;
    localparam int W = 8;
    localparam int C = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    multimode_ff_bank_if #(.WIDTH(W), .CNT_W(C)) bus ();

    multimode_ff_bank #(.WIDTH(W), .CNT_W(C), .RESET_VAL(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [W-1:0] lv, input logic e,
                         input logic [1:0] m, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic clr);
        bus.load     = ld;
        bus.load_val = lv;
        bus.en       = e;
        bus.mode     = m;
        bus.a        = ia;
        bus.b        = ib;
        bus.clr_err  = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] exp_q;
    logic [W-1:0] nq;
    logic [C-1:0] exp_cnt;
    logic         r_ld, r_en;
    logic [W-1:0] r_lv, r_a;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        #2;
        check("reset_q",     bus.q,        8'h00);
        check("reset_qn",    bus.qn,       8'hFF);
        check("reset_err",   bus.err,      1'b0);
        check("reset_cnt",   bus.chg_cnt,  8'd0);
        #12 rst_n = 1'b1;

        // Async reset mid-cycle from q=A5
        drive(1'b1, 8'hA5, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        check("load_a5",     bus.q,        8'hA5);
        check("load_a5_cnt", bus.chg_cnt,  8'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_q",     bus.q,        8'h00);
        check("async_qn",    bus.qn,       8'hFF);
        check("async_err",   bus.err,      1'b0);
        check("async_mask",  bus.err_mask, 8'h00);
        check("async_cnt",   bus.chg_cnt,  8'd0);
        #2 rst_n = 1'b1;

        // JK sequence
        drive(1'b0, 8'h00, 1'b1, 2'b10, 8'hFF, 8'h00, 1'b0); tick();
        check("jk_set",      bus.q, 8'hFF);
        drive(1'b0, 8'h00, 1'b1, 2'b10, 8'h00, 8'h00, 1'b0); tick();
        check("jk_hold",     bus.q, 8'hFF);
        drive(1'b0, 8'h00, 1'b1, 2'b10, 8'hFF, 8'hFF, 1'b0); tick();
        check("jk_toggle",   bus.q, 8'h00);
        check("jk_qn",       bus.qn, 8'hFF);
        drive(1'b0, 8'h00, 1'b1, 2'b10, 8'h00, 8'hFF, 1'b0); tick();
        check("jk_reset",    bus.q, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 2'b10, 8'h0F, 8'h0F, 1'b0); tick();
        check("jk_tog_lo",   bus.q, 8'h0F);
        check("jk_cnt",      bus.chg_cnt, 8'd3);

        // SR with illegal bit, then clear with a new illegal bit
        drive(1'b1, 8'h0F, 1'b1, 2'b11, 8'h11, 8'h10, 1'b0); tick();
        check("sr_pre_q",    bus.q, 8'h0F);
        check("sr_pre_cnt",  bus.chg_cnt, 8'd3);
        drive(1'b0, 8'h00, 1'b1, 2'b11, 8'h11, 8'h10, 1'b0); tick();
        check("sr_q",        bus.q, 8'h0F);
        check("sr_mask",     bus.err_mask, 8'h10);
        check("sr_err",      bus.err, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 2'b11, 8'h01, 8'h01, 1'b1); tick();
        check("clr_new_mask", bus.err_mask, 8'h01);
        check("clr_new_q",   bus.q, 8'h0F);
        drive(1'b0, 8'h00, 1'b1, 2'b11, 8'h00, 8'h00, 1'b1); tick();
        check("clr_mask",    bus.err_mask, 8'h00);
        check("clr_err",     bus.err, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 2'b11, 8'hF0, 8'h0F, 1'b0); tick();
        check("sr_setrst",   bus.q, 8'hF0);
        check("sr_sr_cnt",   bus.chg_cnt, 8'd4);

        // Priority: load over en/mode; en=0 holds and ignores SR errors
        drive(1'b1, 8'h3C, 1'b0, 2'b01, 8'hFF, 8'h00, 1'b0); tick();
        check("prio_load",   bus.q, 8'h3C);
        check("prio_cnt",    bus.chg_cnt, 8'd5);
        drive(1'b0, 8'h00, 1'b0, 2'b01, 8'hFF, 8'h00, 1'b0); tick();
        check("hold_q",      bus.q, 8'h3C);
        check("hold_cnt",    bus.chg_cnt, 8'd5);
        drive(1'b0, 8'h00, 1'b0, 2'b11, 8'hFF, 8'hFF, 1'b0); tick();
        check("en0_no_err",  bus.err_mask, 8'h00);
        drive(1'b1, 8'h3C, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0); tick();
        check("load_over_en", bus.q, 8'h3C);
        check("same_load_cnt", bus.chg_cnt, 8'd5);

        // T-mode saturation: 300 toggling edges from cnt=5
        exp_q   = 8'h3C;
        exp_cnt = 8'd5;
        drive(1'b0, 8'h00, 1'b1, 2'b01, 8'h01, 8'h00, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick();
            exp_q = exp_q ^ 8'h01;
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            check("t_q", bus.q, exp_q);
            check("t_cnt", bus.chg_cnt, exp_cnt);
        end
        check("t_sat", bus.chg_cnt, 8'd255);

        // Random D-mode run against a reference model, from a fresh reset
        drive(1'b0, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        exp_q   = 8'h00;
        exp_cnt = 8'd0;
        for (int i = 0; i < 1000; i++) begin
            r_ld = ($urandom_range(0, 7) == 0);
            r_en = $urandom_range(0, 1);
            r_lv = W'($urandom);
            r_a  = W'($urandom);
            drive(r_ld, r_lv, r_en, 2'b00, r_a, W'($urandom), 1'($urandom_range(0, 1)));
            nq = r_ld ? r_lv : (r_en ? r_a : exp_q);
            if (nq != exp_q && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            exp_q = nq;
            tick();
            check("d_q",    bus.q,        exp_q);
            check("d_mask", bus.err_mask, 8'h00);
            check("d_cnt",  bus.chg_cnt,  exp_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
